// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the host write port and the UART transmit state machine.
// Registered read data, occupancy counter, and sticky overflow/underflow flags.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              wr_n,
   input  logic [7:0]        wr_data,
   input  logic              rd_n,
   input  logic              flush,
   input  logic              clr_err,
   output logic [7:0]        dout,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              underflow
);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              rd_ok;
   logic              wr_ok;
   logic              ovf_evt;
   logic              unf_evt;

   assign empty = (level == '0);
   assign full  = (level == (ADDR_W+1)'(DEPTH));

   // A pop frees the slot this edge, so a full FIFO still takes a write alongside a read.
   assign rd_ok   = !rd_n && !empty && !flush;
   assign wr_ok   = !wr_n && (!full || rd_ok) && !flush;
   assign ovf_evt = !wr_n && full && !rd_ok && !flush;
   assign unf_evt = !rd_n && empty && !flush;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         dout      <= 8'h00;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
               rd_ptr <= rd_ptr + 1'b1;
               dout   <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
               2'b10:   level <= level + 1'b1;
               2'b01:   level <= level - 1'b1;
               default: level <= level;
            endcase
         end
         // A new error event in the same clk as clr_err keeps the flag set.
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (unf_evt)      underflow <= 1'b1;
         else if (clr_err) underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: ordering, full/empty corners, flush and async reset.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       aresetn;
   logic       wr_n = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       rd_n = 1'b1;
   logic       flush = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] dout;
   logic       empty;
   logic       full;
   logic [4:0] level;
   logic       overflow;
   logic       underflow;

   int n_assert = 0;
   int n_fail   = 0;

   uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .aresetn(aresetn), .wr_n(wr_n), .wr_data(wr_data), .rd_n(rd_n),
      .flush(flush), .clr_err(clr_err), .dout(dout), .empty(empty), .full(full),
      .level(level), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes; inputs return idle 1 time unit after the edge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic fl, input logic ce);
      wr_n = !w; wr_data = d; rd_n = !r; flush = fl; clr_err = ce;
      @(posedge clk); #1;
      wr_n = 1'b1; rd_n = 1'b1; flush = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0;
      #12;
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      @(posedge clk); #1; aresetn = 1'b1;

      // three writes, gapped single-clk reads
      cyc(1, 8'h11, 0, 0, 0);
      cyc(1, 8'h22, 0, 0, 0);
      cyc(1, 8'h33, 0, 0, 0);
      chk("t1_level3", level, 3);
      cyc(0, 0, 1, 0, 0); chk("t1_rd0", dout, 8'h11); chk("t1_lvl2", level, 2);
      cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      chk("t1_hold", dout, 8'h11);
      cyc(0, 0, 1, 0, 0); chk("t1_rd1", dout, 8'h22);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0); chk("t1_rd2", dout, 8'h33);
      chk("t1_level0", level, 0);
      chk("t1_empty", empty, 1);
      chk("t1_ovf", overflow, 0);
      chk("t1_unf", underflow, 0);

      // fill to DEPTH then one more
      for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
      chk("t2_full", full, 1);
      chk("t2_level16", level, 16);
      chk("t2_ovf_pre", overflow, 0);
      cyc(1, 8'hAA, 0, 0, 0);
      chk("t2_ovf", overflow, 1);
      chk("t2_level_hold", level, 16);
      cyc(0, 0, 0, 0, 1);
      chk("t2_clr_ovf", overflow, 0);

      // full: simultaneous read and write
      cyc(1, 8'h55, 1, 0, 0);
      chk("t3_dout", dout, 8'h00);
      chk("t3_level", level, 16);
      chk("t3_full", full, 1);
      chk("t3_ovf", overflow, 0);
      for (int i = 1; i < 16; i++) begin
         cyc(0, 0, 1, 0, 0);
         chk("t3_drain", dout, 32'(i));
      end
      cyc(0, 0, 1, 0, 0);
      chk("t3_last55", dout, 8'h55);
      chk("t3_empty", empty, 1);

      // empty: simultaneous read and write
      cyc(1, 8'h77, 1, 0, 0);
      chk("t4_unf", underflow, 1);
      chk("t4_dout_hold", dout, 8'h55);
      chk("t4_level", level, 1);
      cyc(0, 0, 1, 0, 0);
      chk("t4_rd77", dout, 8'h77);
      cyc(1, 8'hAA, 1, 0, 1);
      chk("t4_set_wins", underflow, 1);
      cyc(0, 0, 0, 0, 1);
      chk("t4_clr_unf", underflow, 0);
      chk("t4_clr_ovf", overflow, 0);
      cyc(0, 0, 1, 0, 0);
      chk("t4_rdAA", dout, 8'hAA);

      // pointer wrap
      for (int i = 0; i < 24; i++) begin
         cyc(1, 8'(8'h80 + i), 0, 0, 0);
         chk("t5_lvl1", level, 1);
         cyc(0, 0, 1, 0, 0);
         chk("t5_data", dout, 32'(8'h80 + i));
         chk("t5_lvl0", level, 0);
      end

      // flush with a concurrent write
      cyc(1, 8'h42, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("t6_dout42", dout, 8'h42);
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
      chk("t6_level5", level, 5);
      cyc(1, 8'h99, 1, 1, 0);
      chk("t6_level0", level, 0);
      chk("t6_empty", empty, 1);
      chk("t6_dout", dout, 8'h42);
      chk("t6_ovf", overflow, 0);
      cyc(1, 8'h01, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      chk("t6_post", dout, 8'h01);

      // async reset mid-burst with a flag set
      cyc(0, 0, 1, 0, 0);
      chk("t7_unf_pre", underflow, 1);
      wr_n = 1'b0; wr_data = 8'h3C;
      @(posedge clk); @(posedge clk); @(posedge clk); #3;
      chk("t7_level_pre", level, 3);
      aresetn = 1'b0;
      #1;
      chk("t7_level", level, 0);
      chk("t7_empty", empty, 1);
      chk("t7_full", full, 0);
      chk("t7_dout", dout, 8'h00);
      chk("t7_ovf", overflow, 0);
      chk("t7_unf", underflow, 0);
      wr_n = 1'b1;
      @(posedge clk); #1; aresetn = 1'b1;
      cyc(0, 0, 0, 0, 0);
      chk("t7_stay", level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
